// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and address-field geometry.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W     = 32;
  localparam int APB_DATA_W     = 32;
  localparam int APB_PSEL_W     = 3;
  localparam int APB_BYTE_OFS_W = 2;
  // Top bit of the 4 KiB slave window; higher address bits are ignored.
  localparam int APB_WINDOW_MSB = 11;
  localparam int WAIT_CTR_W     = 3;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with zero flag, used to stretch the APB access phase.
module apb_wait_ctr
  import apb_pkg::*;
#(
  parameter int W = WAIT_CTR_W
) (
  input  logic         hclk,
  input  logic         hreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Saturates at zero so a stray decrement never wraps.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave exposing DEPTH 32-bit registers, with optional wait states and
// out-of-range error reporting.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int SLV_IDX     = 0,
  parameter int WAIT_STATES = 0,
  parameter int DEPTH       = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [APB_PSEL_W-1:0] psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int FIELD_LSB = IDX_W + APB_BYTE_OFS_W;
  // The first penable cycle is spent in SETUP, so ACCESS needs one fewer stall.
  localparam int WS_M1     = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
  localparam logic [WAIT_CTR_W-1:0] WS_LOAD = WS_M1[WAIT_CTR_W-1:0];

  apb_state_e state, next_state;

  logic                                sel;
  logic [APB_WINDOW_MSB:APB_BYTE_OFS_W] addr_q, xfer_addr;
  logic [APB_DATA_W-1:0]               wdata_q, xfer_wdata;
  logic                                write_q, xfer_write;
  logic [IDX_W-1:0]                    xfer_idx;
  logic                                xfer_err;
  logic                                wr_en, rd_en;
  logic [APB_DATA_W-1:0]               rd_data, prdata_q;
  logic [APB_DATA_W-1:0]               regs [DEPTH];
  logic                                ctr_load, ctr_zero;
  logic [WAIT_CTR_W-1:0]               ctr_count;
  logic                                unused_bits;

  assign sel = psel[SLV_IDX];

  apb_wait_ctr #(.W(WAIT_CTR_W)) u_wait_ctr (
    .hclk     (hclk),
    .hreset   (hreset),
    .load     (ctr_load),
    .load_val (WS_LOAD),
    .dec      (!ctr_load),
    .count    (ctr_count),
    .zero     (ctr_zero)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero-wait transfer completes while still in SETUP, so pready follows
  // the live bus there and the master sees it in its first penable cycle.
  always_comb begin
    next_state = state;
    ctr_load   = 1'b0;
    pready     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel && !penable) next_state = SETUP;
      end
      SETUP: begin
        if (!sel) begin
          next_state = IDLE;
        end else if (penable) begin
          if (WAIT_STATES == 0) begin
            pready     = 1'b1;
            next_state = IDLE;
          end else begin
            ctr_load   = 1'b1;
            next_state = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!sel || !penable) begin
          next_state = IDLE;
        end else if (ctr_zero) begin
          pready     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if ((state == SETUP) && sel && penable) begin
      addr_q  <= paddr[APB_WINDOW_MSB:APB_BYTE_OFS_W];
      wdata_q <= pwdata;
      write_q <= pwrite;
    end
  end

  assign xfer_addr  = (state == SETUP) ? paddr[APB_WINDOW_MSB:APB_BYTE_OFS_W] : addr_q;
  assign xfer_wdata = (state == SETUP) ? pwdata : wdata_q;
  assign xfer_write = (state == SETUP) ? pwrite : write_q;
  assign xfer_idx   = xfer_addr[FIELD_LSB-1:APB_BYTE_OFS_W];
  assign xfer_err   = |xfer_addr[APB_WINDOW_MSB:FIELD_LSB];

  assign pslverr = pready && xfer_err;
  assign wr_en   = pready && xfer_write && !xfer_err;
  assign rd_en   = pready && !xfer_write;
  assign rd_data = xfer_err ? '0 : regs[xfer_idx];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[xfer_idx] <= xfer_wdata;
    end
  end

  // prdata is live during a read completion and holds its value otherwise.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      prdata_q <= '0;
    end else if (rd_en) begin
      prdata_q <= rd_data;
    end
  end

  assign prdata = rd_en ? rd_data : prdata_q;

  assign unused_bits = ^{psel, paddr[APB_ADDR_W-1:APB_WINDOW_MSB+1],
                         paddr[APB_BYTE_OFS_W-1:0], ctr_count};

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Two register-file slaves on one APB bus (zero-wait and two-wait), checked
// against an array model with directed and random transfers.
module tb_apb_slave_regfile;

  logic        hclk;
  logic        hreset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [2][16];
  logic [31:0] last_rd [2];

  localparam int WAIT_LIMIT = 20;

  apb_slave_regfile #(.SLV_IDX(0), .WAIT_STATES(0), .DEPTH(16)) dut0 (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_regfile #(.SLV_IDX(1), .WAIT_STATES(2), .DEPTH(8)) dut1 (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int depth_of(input int s);
    return (s == 0) ? 16 : 8;
  endfunction

  function automatic int waits_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  function automatic logic ready_of(input int s);
    return (s == 0) ? pready0 : pready1;
  endfunction

  function automatic logic err_of(input int s);
    return (s == 0) ? pslverr0 : pslverr1;
  endfunction

  function automatic logic [31:0] rdata_of(input int s);
    return (s == 0) ? prdata0 : prdata1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) mem[s][i] = 32'h0;
      last_rd[s] = 32'h0;
    end
  endtask

  // One complete APB transfer to slave s, checked against the model.
  task automatic apply_stimulus(input int s, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata);
    int          word;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          waits;
    bit          done;
    word    = int'((addr & 32'hFFF) >> 2);
    exp_err = (word >= depth_of(s));
    exp_rd  = wr ? last_rd[s] : (exp_err ? 32'h0 : mem[s][word]);
    psel    = 3'(1 << s);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge hclk);
    check_output($sformatf("setup_pready_s%0d", s), 32'(ready_of(s)), 32'h0);
    @(posedge hclk); #1;
    penable = 1'b1;
    waits   = 0;
    done    = 1'b0;
    while (!done && (waits <= WAIT_LIMIT)) begin
      @(negedge hclk);
      check_output($sformatf("other_pready_s%0d", 1 - s), 32'(ready_of(1 - s)), 32'h0);
      if (ready_of(s)) begin
        done = 1'b1;
        check_output($sformatf("waits_s%0d_a%h", s, addr), 32'(waits), 32'(waits_of(s)));
        check_output($sformatf("pslverr_s%0d_a%h", s, addr), 32'(err_of(s)), 32'(exp_err));
        check_output($sformatf("prdata_s%0d_a%h", s, addr), rdata_of(s), exp_rd);
      end else begin
        waits++;
      end
      @(posedge hclk); #1;
    end
    if (!done) check_output($sformatf("timeout_s%0d_a%h", s, addr), 32'h0, 32'h1);
    if (wr && !exp_err) mem[s][word] = wdata;
    if (!wr) last_rd[s] = exp_rd;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    int          s;
    hreset  = 1'b1;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    clear_model();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check_output("rst_pready0", 32'(pready0), 32'h0);
    check_output("rst_pready1", 32'(pready1), 32'h0);
    check_output("rst_pslverr0", 32'(pslverr0), 32'h0);
    check_output("rst_pslverr1", 32'(pslverr1), 32'h0);
    check_output("rst_prdata0", prdata0, 32'h0);
    check_output("rst_prdata1", prdata1, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    $display("[TB] zero-wait write/read");
    apply_stimulus(0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    apply_stimulus(0, 1'b0, 32'h0000_0008, 32'h0);

    $display("[TB] two-wait read after reset");
    apply_stimulus(1, 1'b0, 32'h0000_0004, 32'h0);

    $display("[TB] back-to-back writes and reads");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b1, 32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1'b0, 32'(i * 4), 32'h0);

    $display("[TB] out-of-range write and read");
    apply_stimulus(0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF);
    apply_stimulus(0, 1'b0, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 16; i++) apply_stimulus(0, 1'b0, 32'(i * 4), 32'h0);

    $display("[TB] psel for the other slave only");
    apply_stimulus(1, 1'b1, 32'h0000_0000, 32'h0000_0BAD);
    apply_stimulus(0, 1'b0, 32'h0000_0000, 32'h0);
    apply_stimulus(1, 1'b0, 32'h0000_0000, 32'h0);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 40; n++) begin
      s = int'($urandom_range(0, 1));
      a = 32'(($urandom_range(0, 23) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | (32'h1000 * 32'($urandom_range(1, 15)));
      apply_stimulus(s, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] abort during wait states");
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_000C; pwdata = 32'h5555_AAAA;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    psel = 3'b000; penable = 1'b0;
    @(negedge hclk);
    check_output("abort_pready1", 32'(pready1), 32'h0);
    check_output("abort_pslverr1", 32'(pslverr1), 32'h0);
    @(posedge hclk); #1;
    apply_stimulus(1, 1'b0, 32'h0000_000C, 32'h0);

    $display("[TB] reset during access");
    apply_stimulus(0, 1'b1, 32'h0000_0014, 32'h7777_0001);
    apply_stimulus(0, 1'b0, 32'h0000_0014, 32'h0);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0010; pwdata = 32'h0000_1234;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #2;
    hreset = 1'b1;
    #1;
    check_output("midrst_pready1", 32'(pready1), 32'h0);
    check_output("midrst_pslverr1", 32'(pslverr1), 32'h0);
    check_output("midrst_prdata0", prdata0, 32'h0);
    check_output("midrst_prdata1", prdata1, 32'h0);
    psel = 3'b000; penable = 1'b0;
    clear_model();
    @(posedge hclk); #1;
    hreset = 1'b0;
    apply_stimulus(1, 1'b0, 32'h0000_0010, 32'h0);
    apply_stimulus(0, 1'b0, 32'h0000_0014, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
